// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S master transmitter.
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN
    } tx_state_t;

    localparam int   SLOT_BITS  = 24;
    localparam int   FRAME_BITS = 48;
    localparam logic WS_LEFT    = 1'b0;

    // Word select for a bit position: high over 23..46, so it leads each MSB by one bit.
    function automatic logic ws_for_pos(input logic [5:0] p);
        return ((p >= 6'd23) && (p <= 6'd46)) ? ~WS_LEFT : WS_LEFT;
    endfunction

endpackage

// File: rtl/i2s_sclk_div.sv
// Bit-clock divider: down-counter toggling sclk every SCLK_HALF clks while running.
module i2s_sclk_div #(
    parameter int SCLK_HALF = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int              CW     = $clog2(SCLK_HALF);
    localparam logic [CW-1:0]   RELOAD = CW'(SCLK_HALF - 1);

    logic [CW-1:0] cnt;
    logic          tc;

    assign tc        = run && (cnt == '0);
    assign rise_tick = tc && !sclk;
    assign fall_tick = tc && sclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= RELOAD;
            sclk <= 1'b0;
        end else if (clr) begin
            cnt  <= RELOAD;
            sclk <= 1'b0;
        end else if (run) begin
            if (tc) begin
                cnt  <= RELOAD;
                sclk <= ~sclk;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/i2s_master_tx.sv
// I2S master transmitter: 48-bit stereo frames, one-bit ws delay, MSB first.
//   state | meaning
//   IDLE  | bus parked (sclk 0, ws 1, data 0), divider cleared
//   START | one clk: force p = 47, restart divider
//   RUN   | shifting frames; leaves at frame end when en is low
module i2s_master_tx
    import i2s_pkg::*;
#(
    parameter int SCLK_HALF = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [SLOT_BITS-1:0] lft_in,
    input  logic [SLOT_BITS-1:0] rght_in,
    input  logic                 in_vld,
    output logic                 in_rdy,
    output logic                 I2S_sclk,
    output logic                 I2S_ws,
    output logic                 I2S_data,
    output logic                 underrun
);

    tx_state_t             state;
    logic [5:0]            pos;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] hold;
    logic                  full;
    logic                  accept;
    logic                  frame_end;
    logic                  load;
    logic                  fall_tick;
    logic                  sclk_rise_unused;

    i2s_sclk_div #(
        .SCLK_HALF(SCLK_HALF)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (state != RUN),
        .run       (state == RUN),
        .sclk      (I2S_sclk),
        .rise_tick (sclk_rise_unused),
        .fall_tick (fall_tick)
    );

    assign in_rdy    = ~full;
    assign accept    = in_vld && !full;
    assign frame_end = (state == RUN) && fall_tick && (pos == 6'd47);
    assign load      = frame_end && en;
    assign I2S_data  = shreg[FRAME_BITS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pos      <= 6'd47;
            shreg    <= '0;
            I2S_ws   <= ~WS_LEFT;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            case (state)
                IDLE: begin
                    I2S_ws <= ~WS_LEFT;
                    shreg  <= '0;
                    if (en) state <= START;
                end
                START: begin
                    pos    <= 6'd47;
                    I2S_ws <= WS_LEFT;
                    shreg  <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    if (fall_tick) begin
                        if (pos == 6'd47) begin
                            if (!en) begin
                                // frame finished with no run request: park without loading
                                state  <= IDLE;
                                I2S_ws <= ~WS_LEFT;
                                shreg  <= '0;
                            end else begin
                                pos    <= 6'd0;
                                I2S_ws <= ws_for_pos(6'd0);
                                if (full) begin
                                    shreg <= hold;
                                end else begin
                                    shreg    <= '0;
                                    underrun <= 1'b1;
                                end
                            end
                        end else begin
                            pos    <= pos + 6'd1;
                            I2S_ws <= ws_for_pos(pos + 6'd1);
                            shreg  <= {shreg[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            hold <= '0;
        end else if (load && full) begin
            full <= 1'b0;
        end else if (accept) begin
            full <= 1'b1;
            hold <= {lft_in, rght_in};
        end
    end

endmodule

// File: tb/tb_i2s_master_tx.sv
// Randomized bench for i2s_master_tx with a time-based frame model and a loopback receiver.
module tb_i2s_master_tx;

    localparam int H         = 4;
    localparam int FRAME_CLK = 96 * H;
    localparam int LIM       = 4 * FRAME_CLK;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        in_vld = 1'b0;
    logic [23:0] lft_in = '0;
    logic [23:0] rght_in = '0;
    logic        in_rdy, I2S_sclk, I2S_ws, I2S_data, underrun;

    i2s_master_tx #(.SCLK_HALF(H)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .lft_in   (lft_in),
        .rght_in  (rght_in),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .I2S_sclk (I2S_sclk),
        .I2S_ws   (I2S_ws),
        .I2S_data (I2S_data),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    // Model: outputs derived from clks elapsed since RUN began (m) and the frame words loaded.
    int          m_st = 0;        // 0 idle, 1 start, 2 run
    int          m = 0;
    int          m_pos = 47;
    int          m_loads = 0;
    bit          m_full = 0;
    bit          m_acc = 0;
    logic [47:0] m_hold = '0;
    logic [47:0] m_frame = '0;
    bit          e_sclk = 0, e_ws = 1, e_data = 0, e_und = 0, e_rdy = 1;
    logic [47:0] log_q[$];

    always @(posedge clk or negedge rst_n) begin
        int f, p;
        if (!rst_n) begin
            m_st = 0; m = 0; m_pos = 47; m_full = 0; m_acc = 0;
            e_sclk = 0; e_ws = 1; e_data = 0; e_und = 0; e_rdy = 1;
        end else begin
            m_acc = in_vld && !m_full;
            e_und = 0;
            if (m_st == 2) begin
                m++;
                e_sclk = ((m / H) % 2) == 1;
                if (m % (2 * H) == 0) begin
                    f = m / (2 * H);
                    p = (f - 1) % 48;
                    if (p == 0 && !en) begin
                        m_st = 0; e_sclk = 0; e_ws = 1; e_data = 0;
                    end else begin
                        if (p == 0) begin
                            if (m_full) begin
                                m_frame = m_hold;
                                m_full  = 0;
                            end else begin
                                m_frame = '0;
                                e_und   = 1;
                            end
                            log_q.push_back(m_frame);
                            m_loads++;
                        end
                        m_pos  = p;
                        e_ws   = (p >= 23) && (p <= 46);
                        e_data = m_frame[47 - p];
                    end
                end
            end else if (m_st == 1) begin
                m_st = 2; m = 0; m_pos = 47; m_frame = '0;
                e_sclk = 0; e_ws = 0; e_data = 0;
            end else if (en) begin
                m_st = 1;
            end
            if (m_acc) begin
                m_full = 1;
                m_hold = {lft_in, rght_in};
            end
            e_rdy = !m_full;
        end
    end

    function automatic bit next_is_load();
        return (m_st == 2) && (((m + 1) % (2 * H)) == 0) && (((((m + 1) / (2 * H)) - 1) % 48) == 0);
    endfunction

    int          n_vec = 0;
    int          n_err = 0;
    int          und_cnt = 0;
    int          rx_base = 0, log_base = 0;
    logic [47:0] rx_q[$];
    logic [47:0] last_acc = '0;

    task automatic cmp_bit(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    // Per-cycle compare plus a loopback receiver capturing data on sclk rise.
    task automatic compare_loop();
        bit          prev_sclk = 0;
        bit          prev_ws = 1;
        int          nbits = 0;
        logic [47:0] rx = '0;
        forever begin
            @(negedge clk);
            cmp_bit("sclk", I2S_sclk, e_sclk);
            cmp_bit("ws", I2S_ws, e_ws);
            cmp_bit("data", I2S_data, e_data);
            cmp_bit("underrun", underrun, e_und);
            cmp_bit("in_rdy", in_rdy, e_rdy);
            if (underrun === 1'b1) und_cnt++;
            if (!rst_n) begin
                nbits = 0; prev_ws = 1; prev_sclk = 0;
            end else begin
                if (I2S_sclk && !prev_sclk) begin
                    rx = {rx[46:0], I2S_data};
                    nbits++;
                    if (!I2S_ws && prev_ws) begin
                        if (nbits >= 48) rx_q.push_back(rx);
                        nbits = 0;
                    end
                    prev_ws = I2S_ws;
                end
                prev_sclk = I2S_sclk;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input int ncyc, input bit vld);
        for (int i = 0; i < ncyc; i++) begin
            in_vld = vld;
            step();
            if (m_acc) begin
                last_acc = {lft_in, rght_in};
                lft_in   = 24'($urandom);
                rght_in  = 24'($urandom);
            end
        end
    endtask

    task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
        int g = 0;
        lft_in = l; rght_in = r; in_vld = 1;
        do begin step(); g++; end while (!m_acc && g < LIM);
        if (!m_acc) timeout("send_pair");
        else last_acc = {l, r};
        in_vld = 0;
    endtask

    task automatic wait_loads(input int k, input bit vld);
        int tgt = m_loads + k;
        int g = 0;
        while (m_loads < tgt && g < LIM) begin run_stream(1, vld); g++; end
        if (m_loads < tgt) timeout("wait_loads");
    endtask

    task automatic wait_pos(input int p, input bit vld);
        int g = 0;
        while (!(m_st == 2 && m_pos == p) && g < LIM) begin run_stream(1, vld); g++; end
        if (!(m_st == 2 && m_pos == p)) timeout("wait_pos");
    endtask

    task automatic wait_idle();
        int g = 0;
        while (m_st != 0 && g < LIM) begin run_stream(1, 0); g++; end
        if (m_st != 0) timeout("wait_idle");
        step();
    endtask

    task automatic check_frames(input string nm);
        int nr = rx_q.size() - rx_base;
        int nl = log_q.size() - log_base;
        chk({nm, "_frame_count"}, 48'(nr), 48'(nl));
        for (int i = 0; i < nr && i < nl; i++)
            chk({nm, "_frame"}, rx_q[rx_base + i], log_q[log_base + i]);
        rx_base  = rx_q.size();
        log_base = log_q.size();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int und_base, ld0, g, nr;
        fork
            compare_loop();
        join_none
        repeat (3) step();
        rst_n = 1;
        repeat (5) step();

        // single pair offered during the first frame
        und_base = und_cnt;
        ld0 = m_loads;
        en = 1;
        repeat (20) step();
        send_pair(24'hA5F00F, 24'h123456);
        wait_loads(ld0 + 2 - m_loads, 0);
        wait_pos(10, 0);
        en = 0;
        wait_idle();
        nr = rx_q.size() - rx_base;
        chk("A_frames", 48'(nr), 48'd2);
        if (nr >= 2) begin
            chk("A_first_frame_zero", rx_q[rx_base], 48'h0);
            chk("A_second_frame", rx_q[rx_base + 1], 48'hA5F00F_123456);
        end
        chk("A_underruns", 48'(und_cnt - und_base), 48'd1);
        check_frames("A");

        // back-to-back streaming, then one withheld frame
        und_base = und_cnt;
        lft_in = 24'($urandom); rght_in = 24'($urandom);
        en = 1;
        run_stream(6 * FRAME_CLK, 1);
        chk("B_no_underrun", 48'(und_cnt - und_base), 48'd0);
        und_base = und_cnt;
        wait_loads(1, 1);
        wait_loads(1, 0);
        run_stream(2 * FRAME_CLK, 1);
        chk("C_single_underrun", 48'(und_cnt - und_base), 48'd1);

        // stop at p = 10 with a pair held, then restart
        wait_pos(10, 1);
        en = 0;
        in_vld = 0;
        wait_idle();
        run_stream(20, 0);
        chk("D_pair_held", 48'(in_rdy), 48'd0);
        check_frames("BCD");
        en = 1;
        wait_loads(1, 0);
        chk("D_model_sends_held", log_q[log_q.size() - 1], last_acc);
        wait_pos(10, 0);
        en = 0;
        wait_idle();
        chk("D_rx_held", rx_q[rx_q.size() - 1], last_acc);
        check_frames("D");

        // accept in the same clk as a load with holding empty
        und_base = und_cnt;
        en = 1;
        wait_loads(1, 0);
        g = 0;
        while (!next_is_load() && g < LIM) begin run_stream(1, 0); g++; end
        if (!next_is_load()) timeout("E_load_edge");
        lft_in = 24'h0F1E2D; rght_in = 24'hC3B4A5; in_vld = 1;
        step();
        in_vld = 0;
        wait_loads(1, 0);
        wait_pos(10, 0);
        en = 0;
        wait_idle();
        chk("E_underruns", 48'(und_cnt - und_base), 48'd2);
        if (rx_q.size() >= 2) begin
            chk("E_underrun_frame", rx_q[rx_q.size() - 2], 48'h0);
            chk("E_late_pair", rx_q[rx_q.size() - 1], 48'h0F1E2D_C3B4A5);
        end
        check_frames("E");

        // reset mid-frame
        en = 1;
        run_stream(200, 1);
        #2;
        rst_n = 0;
        #1;
        chk("F_sclk", 48'(I2S_sclk), 48'd0);
        chk("F_ws", 48'(I2S_ws), 48'd1);
        chk("F_data", 48'(I2S_data), 48'd0);
        chk("F_rdy", 48'(in_rdy), 48'd1);
        en = 0;
        in_vld = 0;
        repeat (4) step();
        rst_n = 1;
        rx_base  = rx_q.size();
        log_base = log_q.size();
        repeat (5) step();

        // random traffic
        en = 1;
        for (int i = 0; i < 4 * FRAME_CLK; i++) begin
            in_vld  = ($urandom_range(0, 3) != 0);
            lft_in  = 24'($urandom);
            rght_in = 24'($urandom);
            step();
        end
        wait_pos(10, 1);
        en = 0;
        wait_idle();
        check_frames("G");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
